// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-and-add multiplier with valid/ready handshakes
module seq_multiplier #(
  parameter int WIDTH = 6,
  localparam int OUTPUTLENGTH = 2 * WIDTH,
  localparam int CNTWIDTH = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    signed_mode,
  input  logic [WIDTH-1:0]        q,
  input  logic [WIDTH-1:0]        m,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUTLENGTH-1:0] p
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] q_r, m_r;
  logic [OUTPUTLENGTH-1:0] acc, acc_next;
  logic [WIDTH:0] sum;
  logic [CNTWIDTH-1:0] cnt;
  logic sgn_r, sx_r, neg_r;
  always_comb begin
    sum = {1'b0, acc[OUTPUTLENGTH-1:WIDTH]} + (q_r[0] ? {1'b0, m_r} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
    neg_r = sgn_r & sx_r;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      p <= '0;
      q_r <= '0;
      m_r <= '0;
      acc <= '0;
      cnt <= '0;
      sgn_r <= 1'b0;
      sx_r <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid && in_ready) begin
            state <= RUN;
            in_ready <= 1'b0;
            sgn_r <= signed_mode;
            sx_r <= q[WIDTH-1] ^ m[WIDTH-1];
            q_r <= (signed_mode && q[WIDTH-1]) ? -q : q;
            m_r <= (signed_mode && m[WIDTH-1]) ? -m : m;
            acc <= '0;
            cnt <= '0;
          end
        RUN: begin
          acc <= acc_next;
          q_r <= q_r >> 1;
          cnt <= cnt + CNTWIDTH'(1);
          if (cnt == CNTWIDTH'(WIDTH - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            p <= neg_r ? -acc_next : acc_next;
          end
        end
        DONE:
          if (out_ready) begin
            state <= IDLE;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        default: begin
          state <= IDLE;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;
  localparam int W = 6;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [W-1:0] q, m;
  logic [2*W-1:0] p;
  int errors = 0;
  int checks = 0;
  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .q(q), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint pa, pb, pr;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    pr = pa * pb;
    return pr[2*W-1:0];
  endfunction
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      cyc();
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
    end
    q = a;
    m = b;
    signed_mode = s;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      cyc();
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (p !== '0) begin errors++; $display("FAIL reset_p got=%h want=000", p); end
    rst = 1'b0;
    cyc();
  endtask
  task automatic test_unsigned_max;
    out_ready = 1'b1;
    accept(6'd63, 6'd63, 1'b0);
    for (int k = 1; k <= W; k++) begin
      cyc();
      checks++;
      if (out_valid !== (k == W)) begin errors++; $display("FAIL umax_latency cycle=%0d out_valid=%b want=%b", k, out_valid, k == W); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL umax_busy cycle=%0d in_ready=%b want=0", k, in_ready); end
    end
    checks++;
    if (p !== 12'hF81) begin errors++; $display("FAIL umax_p got=%h want=f81", p); end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL umax_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_signed_corners;
    logic [W-1:0] tq [3] = '{6'h20, 6'h3F, 6'h00};
    logic [W-1:0] tm [3] = '{6'h20, 6'h05, 6'h21};
    logic [2*W-1:0] tp [3] = '{12'h400, 12'hFFB, 12'h000};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(tq[i], tm[i], 1'b1);
      wait_out(lat);
      checks++;
      if (lat != W) begin errors++; $display("FAIL signed_latency case=%0d got=%0d want=%0d", i, lat, W); end
      checks++;
      if (p !== tp[i]) begin errors++; $display("FAIL signed_p case=%0d got=%h want=%h", i, p, tp[i]); end
      cyc();
    end
  endtask
  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    accept(6'd7, 6'd9, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != W || p !== 12'd63) begin errors++; $display("FAIL bp_first lat=%0d p=%0d want lat=%0d p=63", lat, p, W); end
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      q = 6'd1;
      m = 6'd1;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || p !== 12'd63 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b p=%0d in_ready=%b want 1/63/0", k, out_valid, p, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer out_valid=%b want=0", out_valid); end
    cyc(8);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_once out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_operand_change;
    int lat;
    out_ready = 1'b1;
    accept(6'd3, 6'd4, 1'b0);
    q = 6'h3F;
    m = 6'h3F;
    signed_mode = 1'b1;
    wait_out(lat);
    checks++;
    if (out_valid !== 1'b1 || p !== 12'd12) begin errors++; $display("FAIL opchange_p out_valid=%b got=%0d want=12", out_valid, p); end
    cyc();
  endtask
  task automatic test_reset_mid;
    int lat;
    logic seen;
    out_ready = 1'b1;
    accept(6'd10, 6'd10, 1'b0);
    cyc(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL rstmid_state in_ready=%b out_valid=%b p=%0d want 1/0/0", in_ready, out_valid, p);
    end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (out_valid === 1'b1 || p === 12'd100) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_ghost discarded product observed=1 want=0"); end
    accept(6'd2, 6'd3, 1'b0);
    wait_out(lat);
    checks++;
    if (out_valid !== 1'b1 || p !== 12'd6) begin errors++; $display("FAIL rstmid_fresh out_valid=%b got=%0d want=6", out_valid, p); end
    cyc();
  endtask
  task automatic test_random;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] want;
    logic [W-1:0] a, b;
    logic s, got;
    int n_in, n_out, t;
    n_in = 0;
    n_out = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 2));
      accept(a, b, s);
      n_in++;
      exp_q.push_back(model(a, b, s));
      got = 1'b0;
      t = 0;
      while (!got && t < 100) begin
        out_ready = ($urandom_range(0, 3) == 0);
        in_valid = ($urandom_range(0, 1) == 1);
        q = W'($urandom);
        m = W'($urandom);
        signed_mode = ($urandom_range(0, 1) == 1);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          n_out++;
          got = 1'b1;
          checks++;
          if (p !== want) begin errors++; $display("FAIL rand_p op=%0d a=%h b=%h s=%b got=%h want=%h", i, a, b, s, p, want); end
        end
        cyc();
        t++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (!got || out_valid !== 1'b0) begin errors++; $display("FAIL rand_deliver op=%0d delivered=%b out_valid_after=%b want 1/0", i, got, out_valid); end
    end
    out_ready = 1'b1;
    cyc(10);
    checks++;
    if (n_in != n_out || out_valid !== 1'b0) begin errors++; $display("FAIL rand_count accepted=%0d delivered=%0d out_valid=%b", n_in, n_out, out_valid); end
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    signed_mode = 1'b0;
    q = '0;
    m = '0;
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
